// File: rtl/uart_frame_link.sv
// -----------------------------------------------------------------------------
// uart_frame_link
// Framing layer between a byte-level UART (rx/tx modules) and an image core.
//  * RX side: collects HEADER, ROWS*COLS payload bytes, optional checksum and
//    FOOTER into an on-chip RAM, then holds the frame (frame_ready) until the
//    core releases it with frame_ack. Bad footer/checksum, inter-byte timeout
//    and bytes arriving while a frame is held produce a one-cycle err_frame.
//  * TX side: latches a RES_BYTES result word and sends
//    HEADER, byte0..byteN-1, [checksum], FOOTER, honouring tx_busy.
// Optional feature macro: CHECKSUM_EN (XOR checksum byte before FOOTER on
// both RX and TX). Default build has no checksum byte.
// Ports:
//  clk, reset_n            clock, asynchronous active-low reset
//  rx_data/rx_valid        received byte + strobe
//  tx_data/tx_start        byte + 1-cycle start to the UART transmitter
//  tx_busy                 transmitter busy
//  rd_addr/rd_data         core read port, 1-cycle registered latency
//  frame_ready/frame_ack   frame-held level / release strobe
//  res_data/res_valid      result word + strobe, taken when res_ready=1
//  res_ready               TX sequencer idle
//  err_frame               1-cycle error pulse
//  frame_count             accepted frame counter (wraps)
// -----------------------------------------------------------------------------
module uart_frame_link #(
    parameter int          ROWS        = 16,
    parameter int          COLS        = 16,
    parameter logic [7:0]  HEADER      = 8'hAA,
    parameter logic [7:0]  FOOTER      = 8'h55,
    parameter int          RES_BYTES   = 4,
    parameter int          TIMEOUT_CYC = 1_000_000,
    localparam int         FRAME       = ROWS * COLS,
    localparam int         AW          = $clog2(FRAME)
) (
    input  logic                   clk,
    input  logic                   reset_n,
    input  logic [7:0]             rx_data,
    input  logic                   rx_valid,
    output logic [7:0]             tx_data,
    output logic                   tx_start,
    input  logic                   tx_busy,
    input  logic [AW-1:0]          rd_addr,
    output logic [7:0]             rd_data,
    output logic                   frame_ready,
    input  logic                   frame_ack,
    input  logic [8*RES_BYTES-1:0] res_data,
    input  logic                   res_valid,
    output logic                   res_ready,
    output logic                   err_frame,
    output logic [15:0]            frame_count
);
    localparam int             TW       = (TIMEOUT_CYC > 1) ? $clog2(TIMEOUT_CYC) : 1;
    localparam int             TIW      = (RES_BYTES > 1) ? $clog2(RES_BYTES) : 1;
    localparam logic [AW-1:0]  LAST_IDX = AW'(FRAME - 1);
    localparam logic [TW-1:0]  TMO_LAST = TW'(TIMEOUT_CYC - 1);
    localparam logic [TIW-1:0] LAST_RES = TIW'(RES_BYTES - 1);

`ifdef CHECKSUM_EN
    typedef enum logic [2:0] {R_HDR, R_DATA, R_CHK, R_FTR, R_HOLD} rx_state_t;
    typedef enum logic [2:0] {T_IDLE, T_HDR, T_PAY, T_CHK, T_FTR, T_WAIT} tx_state_t;
`else
    typedef enum logic [2:0] {R_HDR, R_DATA, R_FTR, R_HOLD} rx_state_t;
    typedef enum logic [2:0] {T_IDLE, T_HDR, T_PAY, T_FTR, T_WAIT} tx_state_t;
`endif

    // ---------------- RX path ----------------
    rx_state_t      rx_state_reg, rx_next;
    logic [AW-1:0]  idx_reg, idx_next;
    logic [TW-1:0]  tmo_reg, tmo_next;
    logic [15:0]    count_reg, count_next;
    logic           err_reg, err_next;
    logic           ready_reg;
    logic           ram_we;
    logic           timed;
    logic           timeout_hit;
    logic [7:0]     ram [FRAME];
    logic [7:0]     rd_data_reg;
`ifdef CHECKSUM_EN
    logic [7:0]     chk_reg, chk_next;
    logic           chk_ok_reg, chk_ok_next;
`endif

    // Inter-byte timer only runs while a frame is partially received.
    always_comb begin
        timed = (rx_state_reg == R_DATA) || (rx_state_reg == R_FTR);
`ifdef CHECKSUM_EN
        if (rx_state_reg == R_CHK) timed = 1'b1;
`endif
        timeout_hit = (TIMEOUT_CYC != 0) && timed && !rx_valid && (tmo_reg == TMO_LAST);
        tmo_next    = (timed && !rx_valid && !timeout_hit) ? tmo_reg + 1'b1 : '0;
    end

    always_comb begin
        rx_next     = rx_state_reg;
        idx_next    = idx_reg;
        count_next  = count_reg;
        err_next    = 1'b0;
        ram_we      = 1'b0;
`ifdef CHECKSUM_EN
        chk_next    = chk_reg;
        chk_ok_next = chk_ok_reg;
`endif
        case (rx_state_reg)
            R_HDR: begin
                if (rx_valid && rx_data == HEADER) begin
                    idx_next = '0;
`ifdef CHECKSUM_EN
                    chk_next = 8'h00;
`endif
                    rx_next  = R_DATA;
                end
            end
            R_DATA: begin
                if (rx_valid) begin
                    ram_we   = 1'b1;
                    idx_next = idx_reg + 1'b1;
`ifdef CHECKSUM_EN
                    chk_next = chk_reg ^ rx_data;
                    if (idx_reg == LAST_IDX) rx_next = R_CHK;
`else
                    if (idx_reg == LAST_IDX) rx_next = R_FTR;
`endif
                end
            end
`ifdef CHECKSUM_EN
            R_CHK: begin
                // Verdict is stored and only reported once the footer arrives.
                if (rx_valid) begin
                    chk_ok_next = (rx_data == chk_reg);
                    rx_next     = R_FTR;
                end
            end
`endif
            R_FTR: begin
                if (rx_valid) begin
`ifdef CHECKSUM_EN
                    if (rx_data == FOOTER && chk_ok_reg) begin
`else
                    if (rx_data == FOOTER) begin
`endif
                        count_next = count_reg + 1'b1;
                        rx_next    = R_HOLD;
                    end else begin
                        err_next = 1'b1;
                        rx_next  = R_HDR;
                    end
                end
            end
            R_HOLD: begin
                // A byte coinciding with the release is silently dropped.
                if (frame_ack)     rx_next  = R_HDR;
                else if (rx_valid) err_next = 1'b1;
            end
            default: rx_next = R_HDR;
        endcase
        if (timeout_hit) begin
            err_next = 1'b1;
            rx_next  = R_HDR;
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            rx_state_reg <= R_HDR;
            idx_reg      <= '0;
            tmo_reg      <= '0;
            count_reg    <= '0;
            err_reg      <= 1'b0;
            ready_reg    <= 1'b0;
`ifdef CHECKSUM_EN
            chk_reg      <= 8'h00;
            chk_ok_reg   <= 1'b0;
`endif
        end else begin
            rx_state_reg <= rx_next;
            idx_reg      <= idx_next;
            tmo_reg      <= tmo_next;
            count_reg    <= count_next;
            err_reg      <= err_next;
            ready_reg    <= (rx_next == R_HOLD);
`ifdef CHECKSUM_EN
            chk_reg      <= chk_next;
            chk_ok_reg   <= chk_ok_next;
`endif
        end
    end

    // Frame RAM: write port from the RX FSM, registered read port for the core.
    always_ff @(posedge clk) begin
        if (ram_we) ram[idx_reg] <= rx_data;
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) rd_data_reg <= 8'h00;
        else          rd_data_reg <= ram[rd_addr];
    end

    // ---------------- TX path ----------------
    tx_state_t              tx_state_reg, tx_next;
    tx_state_t              ret_reg, ret_next;
    logic [8*RES_BYTES-1:0] shift_reg, shift_next;
    logic [TIW-1:0]         tidx_reg, tidx_next;
    logic [7:0]             tdata_reg, tdata_next;
    logic                   tstart_reg, tstart_next;
    logic                   rready_reg;
`ifdef CHECKSUM_EN
    logic [7:0]             tchk_reg, tchk_next;
    logic [7:0]             res_xor;

    always_comb begin
        res_xor = 8'h00;
        for (int i = 0; i < RES_BYTES; i++) res_xor = res_xor ^ res_data[8*i +: 8];
    end
`endif

    // Every send state issues one start and then parks in T_WAIT for a cycle
    // so the transmitter can raise tx_busy; ret_reg says where to resume.
    always_comb begin
        tx_next     = tx_state_reg;
        ret_next    = ret_reg;
        shift_next  = shift_reg;
        tidx_next   = tidx_reg;
        tdata_next  = tdata_reg;
        tstart_next = 1'b0;
`ifdef CHECKSUM_EN
        tchk_next   = tchk_reg;
`endif
        case (tx_state_reg)
            T_IDLE: begin
                if (res_valid && rready_reg) begin
                    shift_next = res_data;
                    tidx_next  = '0;
`ifdef CHECKSUM_EN
                    tchk_next  = res_xor;
`endif
                    tx_next    = T_HDR;
                end
            end
            T_HDR: begin
                if (!tx_busy) begin
                    tdata_next  = HEADER;
                    tstart_next = 1'b1;
                    ret_next    = T_PAY;
                    tx_next     = T_WAIT;
                end
            end
            T_PAY: begin
                if (!tx_busy) begin
                    tdata_next  = shift_reg[7:0];
                    shift_next  = shift_reg >> 8;
                    tidx_next   = tidx_reg + 1'b1;
                    tstart_next = 1'b1;
`ifdef CHECKSUM_EN
                    ret_next    = (tidx_reg == LAST_RES) ? T_CHK : T_PAY;
`else
                    ret_next    = (tidx_reg == LAST_RES) ? T_FTR : T_PAY;
`endif
                    tx_next     = T_WAIT;
                end
            end
`ifdef CHECKSUM_EN
            T_CHK: begin
                if (!tx_busy) begin
                    tdata_next  = tchk_reg;
                    tstart_next = 1'b1;
                    ret_next    = T_FTR;
                    tx_next     = T_WAIT;
                end
            end
`endif
            T_FTR: begin
                if (!tx_busy) begin
                    tdata_next  = FOOTER;
                    tstart_next = 1'b1;
                    ret_next    = T_IDLE;
                    tx_next     = T_WAIT;
                end
            end
            T_WAIT:  tx_next = ret_reg;
            default: tx_next = T_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            tx_state_reg <= T_IDLE;
            ret_reg      <= T_IDLE;
            shift_reg    <= '0;
            tidx_reg     <= '0;
            tdata_reg    <= 8'h00;
            tstart_reg   <= 1'b0;
            rready_reg   <= 1'b1;
`ifdef CHECKSUM_EN
            tchk_reg     <= 8'h00;
`endif
        end else begin
            tx_state_reg <= tx_next;
            ret_reg      <= ret_next;
            shift_reg    <= shift_next;
            tidx_reg     <= tidx_next;
            tdata_reg    <= tdata_next;
            tstart_reg   <= tstart_next;
            rready_reg   <= (tx_next == T_IDLE);
`ifdef CHECKSUM_EN
            tchk_reg     <= tchk_next;
`endif
        end
    end

    assign tx_data     = tdata_reg;
    assign tx_start    = tstart_reg;
    assign rd_data     = rd_data_reg;
    assign frame_ready = ready_reg;
    assign res_ready   = rready_reg;
    assign err_frame   = err_reg;
    assign frame_count = count_reg;

endmodule

// File: tb/tb_uart_frame_link.sv
// -----------------------------------------------------------------------------
// Self-checking bench for uart_frame_link (ROWS=COLS=4, RES_BYTES=4,
// TIMEOUT_CYC=100). Frames are built from byte arrays and judged by the
// framing rules; the transmitter is modelled as a busy-for-N-cycles UART and
// the bytes it receives are compared with the expected packet.
// -----------------------------------------------------------------------------
`timescale 1ns/1ps
module tb_uart_frame_link;
    localparam int         ROWS        = 4;
    localparam int         COLS        = 4;
    localparam int         FRAME       = ROWS * COLS;
    localparam int         AW          = $clog2(FRAME);
    localparam int         RES_BYTES   = 4;
    localparam int         TIMEOUT_CYC = 100;
    localparam logic [7:0] HDR         = 8'hAA;
    localparam logic [7:0] FTR         = 8'h55;
`ifdef CHECKSUM_EN
    localparam bit CHK_ON = 1'b1;
`else
    localparam bit CHK_ON = 1'b0;
`endif

    logic                   clk = 1'b0;
    logic                   reset_n = 1'b0;
    logic [7:0]             rx_data = 8'h00;
    logic                   rx_valid = 1'b0;
    logic [7:0]             tx_data;
    logic                   tx_start;
    logic                   tx_busy = 1'b0;
    logic [AW-1:0]          rd_addr = '0;
    logic [7:0]             rd_data;
    logic                   frame_ready;
    logic                   frame_ack = 1'b0;
    logic [8*RES_BYTES-1:0] res_data = '0;
    logic                   res_valid = 1'b0;
    logic                   res_ready;
    logic                   err_frame;
    logic [15:0]            frame_count;

    uart_frame_link #(
        .ROWS(ROWS), .COLS(COLS), .HEADER(HDR), .FOOTER(FTR),
        .RES_BYTES(RES_BYTES), .TIMEOUT_CYC(TIMEOUT_CYC)
    ) dut (
        .clk(clk), .reset_n(reset_n),
        .rx_data(rx_data), .rx_valid(rx_valid),
        .tx_data(tx_data), .tx_start(tx_start), .tx_busy(tx_busy),
        .rd_addr(rd_addr), .rd_data(rd_data),
        .frame_ready(frame_ready), .frame_ack(frame_ack),
        .res_data(res_data), .res_valid(res_valid), .res_ready(res_ready),
        .err_frame(err_frame), .frame_count(frame_count)
    );

    always #5 clk = ~clk;

    int         checks = 0;
    int         errors = 0;
    int         err_pulses = 0;
    int         start_viol = 0;
    int         busy_left = 0;
    logic       prev_start = 1'b0;
    int         exp_count = 0;
    logic [7:0] pay     [FRAME];
    logic [7:0] exp_ram [FRAME];
    logic [7:0] wire_q  [$];

    task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // Error pulses are counted on the edge after they appear.
    always @(posedge clk) if (err_frame === 1'b1) err_pulses++;

    // UART transmitter model: captures each started byte, then stays busy.
    always @(posedge clk) begin
        if (tx_start === 1'b1) begin
            wire_q.push_back(tx_data);
            busy_left <= $urandom_range(3, 8);
            tx_busy   <= 1'b1;
        end else if (busy_left > 1) begin
            busy_left <= busy_left - 1;
        end else begin
            busy_left <= 0;
            tx_busy   <= 1'b0;
        end
    end

    // A start may never overlap busy nor follow another start directly.
    always @(negedge clk) begin
        if (tx_start === 1'b1 && (tx_busy === 1'b1 || prev_start)) start_viol++;
        prev_start = (tx_start === 1'b1);
    end

    task automatic send_byte(input logic [7:0] b, input int gap);
        @(negedge clk); rx_data = b; rx_valid = 1'b1;
        @(negedge clk); rx_valid = 1'b0;
        repeat (gap) @(negedge clk);
    endtask

    task automatic send_frame(input logic [7:0] ftr, input bit bad_chk);
        logic [7:0] x;
        x = 8'h00;
        send_byte(HDR, $urandom_range(0, 2));
        for (int i = 0; i < FRAME; i++) begin
            send_byte(pay[i], $urandom_range(0, 2));
            x = x ^ pay[i];
        end
        if (CHK_ON) send_byte(bad_chk ? ~x : x, $urandom_range(0, 2));
        send_byte(ftr, $urandom_range(0, 2));
    endtask

    task automatic check_ram(input string tag);
        for (int a = 0; a < FRAME; a++) begin
            @(negedge clk); rd_addr = AW'(a);
            @(negedge clk);
            check_val($sformatf("%s_ram%0d", tag, a), rd_data, exp_ram[a]);
        end
    endtask

    task automatic ack_frame(input string tag, input bit with_byte);
        int e0;
        e0 = err_pulses;
        @(negedge clk); frame_ack = 1'b1;
        if (with_byte) begin rx_data = HDR; rx_valid = 1'b1; end
        @(negedge clk); frame_ack = 1'b0; rx_valid = 1'b0;
        check_val({tag, "_ack_ready"}, frame_ready, 0);
        @(negedge clk);
        check_val({tag, "_ack_err"}, err_pulses - e0, 0);
    endtask

    task automatic run_frame(input logic [7:0] ftr, input bit bad_chk, input bit do_ack, input string tag);
        int e0;
        bit accept;
        e0 = err_pulses;
        send_frame(ftr, bad_chk);
        @(negedge clk);
        accept = (ftr == FTR) && !(CHK_ON && bad_chk);
        if (accept) begin
            for (int i = 0; i < FRAME; i++) exp_ram[i] = pay[i];
            exp_count = (exp_count + 1) & 16'hFFFF;
        end
        $display("frame %s: footer=%02h bad_chk=%0d accept=%0d", tag, ftr, bad_chk, accept);
        check_val({tag, "_ready"}, frame_ready, accept);
        check_val({tag, "_count"}, frame_count, exp_count);
        check_val({tag, "_err"}, err_pulses - e0, accept ? 0 : 1);
        if (accept) begin
            check_ram(tag);
            if (do_ack) ack_frame(tag, 1'b0);
        end
    endtask

    task automatic send_result(input logic [8*RES_BYTES-1:0] d, input string tag);
        logic [7:0] exp_q [$];
        logic [7:0] x;
        int n;
        int v0;
        x = 8'h00;
        exp_q.push_back(HDR);
        for (int i = 0; i < RES_BYTES; i++) begin
            exp_q.push_back(d[8*i +: 8]);
            x = x ^ d[8*i +: 8];
        end
        if (CHK_ON) exp_q.push_back(x);
        exp_q.push_back(FTR);
        n = 0;
        while (res_ready !== 1'b1 && n < 2000) begin @(negedge clk); n++; end
        check_val({tag, "_idle"}, res_ready, 1);
        wire_q.delete();
        v0 = start_viol;
        @(negedge clk); res_data = d; res_valid = 1'b1;
        @(negedge clk); res_valid = 1'b0;
        check_val({tag, "_busy"}, res_ready, 0);
        // A request while busy must be ignored.
        res_data = ~d; res_valid = 1'b1;
        @(negedge clk); res_valid = 1'b0;
        n = 0;
        while (res_ready !== 1'b1 && n < 2000) begin @(negedge clk); n++; end
        check_val({tag, "_done"}, res_ready, 1);
        repeat (15) @(negedge clk);
        $display("result %s: data=%h bytes=%0d", tag, d, wire_q.size());
        check_val({tag, "_len"}, wire_q.size(), exp_q.size());
        for (int i = 0; i < exp_q.size() && i < wire_q.size(); i++)
            check_val($sformatf("%s_b%0d", tag, i), wire_q[i], exp_q[i]);
        check_val({tag, "_startrule"}, start_viol - v0, 0);
    endtask

    task automatic check_reset_vals(input string tag);
        check_val({tag, "_tx_data"}, tx_data, 0);
        check_val({tag, "_tx_start"}, tx_start, 0);
        check_val({tag, "_rd_data"}, rd_data, 0);
        check_val({tag, "_frame_ready"}, frame_ready, 0);
        check_val({tag, "_res_ready"}, res_ready, 1);
        check_val({tag, "_err_frame"}, err_frame, 0);
        check_val({tag, "_frame_count"}, frame_count, 0);
    endtask

    task automatic rand_pay();
        for (int i = 0; i < FRAME; i++) pay[i] = 8'($urandom);
    endtask

    initial begin
        int e0;
        int n;
        int mode;
        logic [7:0] bad;

        repeat (3) @(negedge clk);
        check_reset_vals("rst");
        reset_n = 1'b1;
        @(negedge clk);

        // Spec frame 0x00..0x0F, held for the overrun test.
        for (int i = 0; i < FRAME; i++) pay[i] = 8'(i);
        run_frame(FTR, 1'b0, 1'b0, "spec");
        @(negedge clk); rd_addr = AW'(5);
        @(negedge clk); check_val("spec_rd5", rd_data, 8'h05);

        // Overrun while held: two error pulses, RAM untouched.
        e0 = err_pulses;
        send_byte(8'h12, 0);
        send_byte(8'h34, 0);
        @(negedge clk);
        $display("overrun: 2 bytes while frame held");
        check_val("ovr_err", err_pulses - e0, 2);
        check_val("ovr_ready", frame_ready, 1);
        check_ram("ovr");
        ack_frame("ovr", 1'b1);

        // Bad footer, then recovery.
        run_frame(8'h54, 1'b0, 1'b1, "badftr");
        rand_pay();
        run_frame(FTR, 1'b0, 1'b1, "recover");

        // Timeout: header + 3 bytes then silence.
        e0 = err_pulses;
        send_byte(HDR, 0);
        send_byte(8'h01, 0);
        send_byte(8'h02, 0);
        send_byte(8'h03, 0);
        n = 0;
        for (int c = 1; c <= 300; c++) begin
            @(posedge clk); #1;
            if (err_frame === 1'b1) begin n = c; break; end
        end
        $display("timeout: err after %0d cycles", n);
        check_val("tmo_cycles", n, TIMEOUT_CYC);
        repeat (3) @(negedge clk);
        check_val("tmo_err", err_pulses - e0, 1);
        check_val("tmo_ready", frame_ready, 0);
        check_val("tmo_count", frame_count, exp_count);
        rand_pay();
        run_frame(FTR, 1'b0, 1'b1, "after_tmo");

        // Random frames with junk prefix and random corruption.
        for (int k = 0; k < 6; k++) begin
            for (int j = 0; j < $urandom_range(0, 2); j++) begin
                bad = 8'($urandom);
                if (bad == HDR) bad = 8'h00;
                send_byte(bad, 0);
            end
            rand_pay();
            mode = $urandom_range(0, 2);
            bad = 8'($urandom);
            if (bad == FTR) bad = bad ^ 8'h01;
            run_frame(mode == 1 ? bad : FTR, mode == 2, 1'b1, $sformatf("rnd%0d", k));
        end

        // Result transmission.
        send_result(32'h04030201, "tx_spec");
        for (int k = 0; k < 3; k++) send_result($urandom, $sformatf("tx_rnd%0d", k));

        // RX and TX concurrently.
        rand_pay();
        fork
            send_result($urandom, "tx_conc");
            run_frame(FTR, 1'b0, 1'b1, "rx_conc");
        join

        // Reset in the middle of a frame and a transmission.
        @(negedge clk); res_data = $urandom; res_valid = 1'b1;
        @(negedge clk); res_valid = 1'b0;
        send_byte(HDR, 0);
        for (int i = 0; i < 5; i++) send_byte(8'($urandom), 0);
        #1 reset_n = 1'b0;
        #1 check_reset_vals("midrst");
        repeat (2) @(negedge clk);
        reset_n = 1'b1;
        exp_count = 0;
        repeat (20) @(negedge clk);
        rand_pay();
        run_frame(FTR, 1'b0, 1'b1, "post_rst");
        send_result($urandom, "tx_post_rst");

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    // Hard stop in case a stimulus path stalls.
    initial begin
        #2_000_000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog expired");
    end
endmodule
